// File: rtl/reg_writeback.sv
// Register-file write-port initiator: merges ALU results and FIFO-buffered load
// results onto one write port and keeps the pending-load scoreboard for decode.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     ld_issue,
  input  logic [4:0]               ld_issue_rd,
  output logic [4:0]               wa,
  output logic [XLEN-1:0]          wda,
  output logic                     reg_wr,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   ld_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshakes: a transfer happens when valid and ready are high in the same
  // cycle; ready depends only on registered occupancy (and reset), never on valid.

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic            full, empty;
  logic            alu_fire, ld_fire, deq;
  logic            grant;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic [31:0]     pending_next;

  assign full  = (ld_count == FULL_CNT);
  assign empty = (ld_count == '0);

  // Ready is forced high during reset, but reset also blocks every transfer.
  assign alu_ready = reset | ~full;
  assign ld_ready  = reset | ~full;

  assign alu_fire = alu_valid & alu_ready & ~reset;
  assign ld_fire  = ld_valid & ld_ready & ~reset;
  assign deq      = ~reset & ~alu_fire & ~empty;

  always_comb begin
    grant      = 1'b0;
    grant_rd   = '0;
    grant_data = '0;
    if (alu_fire) begin
      grant      = 1'b1;
      grant_rd   = alu_rd;
      grant_data = alu_data;
    end else if (deq) begin
      grant      = 1'b1;
      grant_rd   = fifo_rd[rd_ptr];
      grant_data = fifo_data[rd_ptr];
    end
  end

  // Clear first so a same-cycle issue to the same register wins.
  always_comb begin
    pending_next = pending;
    if (deq && fifo_rd[rd_ptr] != 5'd0)
      pending_next[fifo_rd[rd_ptr]] = 1'b0;
    if (ld_issue && ld_issue_rd != 5'd0)
      pending_next[ld_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ld_count <= '0;
      pending  <= '0;
      reg_wr   <= 1'b0;
      wa       <= '0;
      wda      <= '0;
    end else begin
      if (ld_fire) wr_ptr <= wr_ptr + AW'(1);
      if (deq)     rd_ptr <= rd_ptr + AW'(1);
      case ({ld_fire, deq})
        2'b10:   ld_count <= ld_count + (AW+1)'(1);
        2'b01:   ld_count <= ld_count - (AW+1)'(1);
        default: ld_count <= ld_count;
      endcase
      pending <= pending_next;
      reg_wr  <= grant && (grant_rd != 5'd0);
      if (grant) begin
        wa  <= grant_rd;
        wda <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, all checked
// against a queue-based model of the write-port merge and scoreboard.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             alu_valid, alu_ready;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             ld_valid, ld_ready;
  logic [4:0]       ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic             ld_issue;
  logic [4:0]       ld_issue_rd;
  logic [4:0]       wa;
  logic [XLEN-1:0]  wda;
  logic             reg_wr;
  logic [31:0]      pending;
  logic [$clog2(DEPTH):0] ld_count;

  reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .wa(wa), .wda(wda), .reg_wr(reg_wr), .pending(pending), .ld_count(ld_count)
  );

  // reference model state
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;
  ent_t            exp_q[$];
  logic [31:0]     m_pending;
  logic            m_reg_wr;
  logic [4:0]      m_wa;
  logic [XLEN-1:0] m_wda;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
  endtask

  // One clock: check readies, advance the model on current inputs, then check
  // the registered outputs one time unit after the edge.
  task automatic step();
    logic            full;
    logic            g;
    logic [4:0]      grd;
    logic [XLEN-1:0] gd;
    ent_t            head;
    #1;
    full = (exp_q.size() == DEPTH);
    check("alu_ready", alu_ready, reset | !full);
    check("ld_ready",  ld_ready,  reset | !full);
    if (reset) begin
      exp_q.delete();
      m_pending = '0; m_reg_wr = 1'b0; m_wa = '0; m_wda = '0;
    end else begin
      g = 1'b0; grd = '0; gd = '0;
      if (alu_valid && !full) begin
        g = 1'b1; grd = alu_rd; gd = alu_data;
      end else if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        g = 1'b1; grd = head.rd; gd = head.data;
        if (grd != 0) m_pending[grd] = 1'b0;
      end
      if (ld_valid && !full) exp_q.push_back('{ld_rd, ld_data});
      if (ld_issue && ld_issue_rd != 0) m_pending[ld_issue_rd] = 1'b1;
      m_reg_wr = g && (grd != 0);
      if (g) begin m_wa = grd; m_wda = gd; end
    end
    @(posedge clk);
    #1;
    check("reg_wr",   reg_wr,   m_reg_wr);
    check("wa",       wa,       m_wa);
    check("wda",      wda,      m_wda);
    check("pending",  pending,  m_pending);
    check("ld_count", ld_count, exp_q.size());
  endtask

  initial begin
    reset = 1'b1; idle();
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0; ld_issue_rd = '0;
    step(); step();
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_count",  ld_count, 0);
    reset = 1'b0;
    step();

    // single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    check("alu1_wr", reg_wr, 1'b1);
    check("alu1_wa", wa, 5'd5);
    check("alu1_wda", wda, 32'hDEADBEEF);
    idle(); step();
    check("alu1_wr_off", reg_wr, 1'b0);

    // load with scoreboard
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    check("ld_pend_set", pending[7], 1'b1);
    step(); step();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    step();
    ld_valid = 1'b0;
    check("ld_no_wr_yet", reg_wr, 1'b0);
    step();
    check("ld_wr", reg_wr, 1'b1);
    check("ld_wa", wa, 5'd7);
    check("ld_wda", wda, 32'h1234);
    check("ld_pend_clr", pending[7], 1'b0);

    // full FIFO with ALU contention
    alu_valid = 1'b1; alu_rd = 5'd10;
    for (int i = 1; i <= 4; i++) begin
      alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h11 * i;
      step();
    end
    ld_valid = 1'b0;
    check("full_count", ld_count, 4);
    check("full_ld_rdy", ld_ready, 1'b0);
    check("full_alu_rdy", alu_ready, 1'b0);
    step();
    check("drain_wa1", wa, 5'd1);
    check("drain_count3", ld_count, 3);
    check("alu_rdy_back", alu_ready, 1'b1);
    alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("drain_wa", wa, 5'(i));
      check("drain_wr", reg_wr, 1'b1);
    end

    // x0 discard
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
    step();
    check("x0_alu_wr", reg_wr, 1'b0);
    idle(); step();
    check("x0_ld_wr", reg_wr, 1'b0);
    check("x0_count", ld_count, 0);
    check("x0_pend0", pending[0], 1'b0);

    // set/clear collision
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0; ld_valid = 1'b1; ld_rd = 5'd9; ld_data = $urandom;
    step();
    ld_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    check("coll_wa", wa, 5'd9);
    check("coll_pend9", pending[9], 1'b1);

    // reset mid-operation
    alu_valid = 1'b1; alu_rd = 5'd20;
    for (int i = 0; i < 3; i++) begin
      alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = 5'(11 + i); ld_data = $urandom;
      step();
    end
    ld_valid = 1'b0;
    check("mid_count3", ld_count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reg_wr", reg_wr, 1'b0);
    check("mid_count0", ld_count, 0);
    check("mid_pending", pending, 32'h0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_wr", reg_wr, 1'b0);
    end

    // random traffic
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 79) == 0);
      alu_valid   = ($urandom_range(0, 99) < 60);
      alu_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 45);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      ld_issue    = ($urandom_range(0, 99) < 40);
      ld_issue_rd = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0; idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("final_count", ld_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
